// File: rtl/fetch_controller.sv
// Instruction fetch sequencer: owns the PC, reads the combinational instruction
// memory and queues {pc, word} pairs in a small FIFO drained by decode.
module fetch_controller #(
    parameter logic [31:0] RESET_PC   = 32'h0,
    parameter int          MEM_WORDS  = 64,
    parameter int          FIFO_DEPTH = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        halt,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_rdata,
    output logic        inst_valid,
    input  logic        inst_ready,
    output logic [31:0] inst_data,
    output logic [31:0] inst_pc,
    output logic        busy,
    output logic        fault
);

    localparam int              PW       = $clog2(FIFO_DEPTH);
    localparam int              CW       = PW + 1;
    localparam logic [31:0]     PC_LIMIT = 32'(MEM_WORDS * 4);
    localparam logic [CW-1:0]   DEPTH_C  = CW'(FIFO_DEPTH);

    typedef enum logic [1:0] {
        S_IDLE,
        S_FETCH,
        S_FAULT
    } state_t;

    state_t          state_q, state_d;
    logic [31:0]     pc_q, pc_d;
    logic [PW-1:0]   head_q, head_d;
    logic [PW-1:0]   tail_q, tail_d;
    logic [CW-1:0]   count_q, count_d;
    logic [31:0]     fpc_q   [FIFO_DEPTH];
    logic [31:0]     fpc_d   [FIFO_DEPTH];
    logic [31:0]     fdata_q [FIFO_DEPTH];
    logic [31:0]     fdata_d [FIFO_DEPTH];

    logic            pop_req;
    logic            push;
    logic            pop;
    logic            flush;

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        fpc_d   = fpc_q;
        fdata_d = fdata_q;
        push    = 1'b0;
        pop     = 1'b0;
        flush   = 1'b0;
        pop_req = (count_q != '0) && inst_ready;

        // Redirect outranks every state action; a bad target parks us in FAULT.
        if (state_q != S_FAULT && redirect_valid) begin
            flush = 1'b1;
            if (redirect_pc[1:0] != 2'b00) begin
                state_d = S_FAULT;
            end else begin
                pc_d = redirect_pc;
                if (halt) state_d = S_IDLE;
            end
        end else begin
            unique case (state_q)
                S_IDLE: begin
                    pop = pop_req;
                    if (start && !halt) state_d = S_FETCH;
                end
                S_FETCH: begin
                    if (halt) begin
                        pop     = pop_req;
                        state_d = S_IDLE;
                    end else if (pc_q >= PC_LIMIT) begin
                        state_d = S_FAULT;
                        flush   = 1'b1;
                    end else begin
                        pop  = pop_req;
                        push = (count_q < DEPTH_C) || pop_req;
                    end
                end
                S_FAULT: begin
                end
                default: begin
                end
            endcase
        end

        if (push) pc_d = pc_q + 32'd4;

        if (flush) begin
            count_d = '0;
            head_d  = '0;
            tail_d  = '0;
        end else begin
            if (pop) head_d = head_q + 1'b1;
            if (push) begin
                fpc_d[tail_q]   = pc_q;
                fdata_d[tail_q] = imem_rdata;
                tail_d          = tail_q + 1'b1;
            end
            if (push && !pop) begin
                count_d = count_q + 1'b1;
            end else if (pop && !push) begin
                count_d = count_q - 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            pc_q    <= RESET_PC;
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                fpc_q[i]   <= '0;
                fdata_q[i] <= '0;
            end
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
            fpc_q   <= fpc_d;
            fdata_q <= fdata_d;
        end
    end

    assign imem_addr  = pc_q;
    assign inst_valid = (count_q != '0) && (state_q != S_FAULT);
    assign inst_data  = fdata_q[head_q];
    assign inst_pc    = fpc_q[head_q];
    assign busy       = (state_q == S_FETCH);
    assign fault      = (state_q == S_FAULT);

endmodule

// File: tb/tb_fetch_controller.sv
// Bench for fetch_controller: directed scenarios then random traffic, all
// checked against a queue-based model of the fetch buffer.
module tb_fetch_controller;

    localparam int          DEPTH = 2;
    localparam logic [31:0] LIMIT = 32'd256;
    localparam int          M_IDLE  = 0;
    localparam int          M_FETCH = 1;
    localparam int          M_FAULT = 2;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] data;
    } ent_t;

    logic        clk;
    logic        rst;
    logic        start;
    logic        halt;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic [31:0] imem_addr;
    logic [31:0] imem_rdata;
    logic        inst_valid;
    logic        inst_ready;
    logic [31:0] inst_data;
    logic [31:0] inst_pc;
    logic        busy;
    logic        fault;

    logic [31:0] mem [64];

    int          n_cmp;
    int          n_err;
    ent_t        q[$];
    logic [31:0] m_pc;
    int          m_st;

    fetch_controller dut (
        .clk            (clk),
        .rst            (rst),
        .start          (start),
        .halt           (halt),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .imem_addr      (imem_addr),
        .imem_rdata     (imem_rdata),
        .inst_valid     (inst_valid),
        .inst_ready     (inst_ready),
        .inst_data      (inst_data),
        .inst_pc        (inst_pc),
        .busy           (busy),
        .fault          (fault)
    );

    assign imem_rdata = (imem_addr < LIMIT) ? mem[imem_addr[7:2]] : 32'hBAD0_0000;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        q.delete();
        m_pc = 32'h0;
        m_st = M_IDLE;
    endtask

    task automatic check_outputs();
        chk("imem_addr", imem_addr, m_pc);
        chk("busy", {31'b0, busy}, {31'b0, m_st == M_FETCH});
        chk("fault", {31'b0, fault}, {31'b0, m_st == M_FAULT});
        chk("inst_valid", {31'b0, inst_valid}, {31'b0, q.size() != 0});
        if (q.size() != 0) begin
            chk("inst_pc", inst_pc, q[0].pc);
            chk("inst_data", inst_data, q[0].data);
        end
    endtask

    // Instruction stream seen by decode: pops from the front, fetches append.
    task automatic model_step();
        bit pop;
        ent_t e;
        pop = (q.size() != 0) && inst_ready && (m_st != M_FAULT);
        if (m_st != M_FAULT && redirect_valid) begin
            q.delete();
            if (redirect_pc[1:0] != 2'b00) begin
                m_st = M_FAULT;
            end else begin
                m_pc = redirect_pc;
                if (halt) m_st = M_IDLE;
            end
        end else if (m_st == M_IDLE) begin
            if (pop) void'(q.pop_front());
            if (start && !halt) m_st = M_FETCH;
        end else if (m_st == M_FETCH) begin
            if (halt) begin
                if (pop) void'(q.pop_front());
                m_st = M_IDLE;
            end else if (m_pc >= LIMIT) begin
                m_st = M_FAULT;
                q.delete();
            end else begin
                if (pop) void'(q.pop_front());
                if (q.size() < DEPTH) begin
                    e.pc   = m_pc;
                    e.data = 32'h1000_0000 + (m_pc >> 2);
                    q.push_back(e);
                    m_pc = m_pc + 32'd4;
                end
            end
        end
    endtask

    task automatic do_cycle();
        check_outputs();
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic async_reset();
        #2;
        rst = 1'b1;
        #1;
        chk("rst_valid", {31'b0, inst_valid}, 32'd0);
        chk("rst_addr", imem_addr, 32'h0);
        chk("rst_busy", {31'b0, busy}, 32'd0);
        chk("rst_fault", {31'b0, fault}, 32'd0);
        model_reset();
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    initial begin
        logic [31:0] rpc;
        int r;
        n_cmp = 0;
        n_err = 0;
        for (int i = 0; i < 64; i++) mem[i] = 32'h1000_0000 + i;
        rst            = 1'b0;
        start          = 1'b0;
        halt           = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = 32'h0;
        inst_ready     = 1'b0;
        model_reset();

        // streaming fetch with decode always ready
        async_reset();
        start      = 1'b1;
        inst_ready = 1'b1;
        do_cycle();
        chk("t1_valid0", {31'b0, inst_valid}, 32'd0);
        do_cycle();
        chk("t1_pc0", inst_pc, 32'h0);
        chk("t1_data0", inst_data, 32'h1000_0000);
        do_cycle();
        chk("t1_pc1", inst_pc, 32'h4);
        for (int i = 0; i < 6; i++) do_cycle();

        // backpressure saturates the buffer
        async_reset();
        inst_ready = 1'b0;
        for (int i = 0; i < 8; i++) do_cycle();
        chk("t2_addr", imem_addr, 32'h8);
        chk("t2_head", inst_pc, 32'h0);
        inst_ready = 1'b1;
        for (int i = 0; i < 4; i++) do_cycle();

        // redirect while full
        async_reset();
        inst_ready = 1'b0;
        for (int i = 0; i < 3; i++) do_cycle();
        chk("t3_full_head", inst_pc, 32'h0);
        redirect_valid = 1'b1;
        redirect_pc    = 32'h20;
        do_cycle();
        redirect_valid = 1'b0;
        chk("t3_flushed", {31'b0, inst_valid}, 32'd0);
        chk("t3_addr", imem_addr, 32'h20);
        do_cycle();
        chk("t3_pc", inst_pc, 32'h20);
        chk("t3_data", inst_data, 32'h1000_0008);

        // misaligned redirect is sticky until reset
        redirect_valid = 1'b1;
        redirect_pc    = 32'h22;
        do_cycle();
        redirect_valid = 1'b0;
        chk("t4_fault", {31'b0, fault}, 32'd1);
        chk("t4_busy", {31'b0, busy}, 32'd0);
        start = 1'b1;
        for (int i = 0; i < 3; i++) do_cycle();
        chk("t4_sticky", {31'b0, fault}, 32'd1);
        async_reset();
        chk("t4_cleared", {31'b0, fault}, 32'd0);

        // run off the end of memory
        start      = 1'b1;
        inst_ready = 1'b1;
        for (int i = 0; i < 70; i++) do_cycle();
        chk("t5_fault", {31'b0, fault}, 32'd1);
        chk("t5_addr", imem_addr, 32'h100);

        // async reset mid-run
        async_reset();
        inst_ready = 1'b0;
        for (int i = 0; i < 4; i++) do_cycle();
        start = 1'b0;
        async_reset();
        for (int i = 0; i < 3; i++) do_cycle();
        chk("t6_idle", {31'b0, busy}, 32'd0);
        start = 1'b1;
        for (int i = 0; i < 3; i++) do_cycle();

        // random traffic
        for (int i = 0; i < 800; i++) begin
            inst_ready = ($urandom_range(0, 3) != 0);
            start      = ($urandom_range(0, 3) != 0);
            halt       = ($urandom_range(0, 15) == 0);
            redirect_valid = ($urandom_range(0, 14) == 0);
            r = $urandom_range(0, 9);
            if (r == 0) rpc = {24'h0, 6'($urandom_range(0, 63)), 2'($urandom_range(1, 3))};
            else if (r == 1) rpc = 32'hF0 + {28'h0, 2'($urandom_range(0, 3)), 2'b00};
            else if (r == 2) rpc = 32'h200;
            else rpc = {24'h0, 6'($urandom_range(0, 63)), 2'b00};
            redirect_pc = rpc;
            do_cycle();
            if ($urandom_range(0, 199) == 0 || (m_st == M_FAULT && $urandom_range(0, 7) == 0)) begin
                async_reset();
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
